// File: rtl/bullet_manager.sv
// Ammunition controller: owns the round count, paces fire through a cooldown and
// refills the magazine one round per reload period.
module bullet_manager #(
  parameter int unsigned MAX_BULLET    = 6,
  parameter int unsigned FIRE_COOLDOWN = 2_500_000,
  parameter int unsigned RELOAD_CYCLES = 12_500_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_req,
  input  logic       reload_req,
  output logic [4:0] leftBullet,
  output logic       shot,
  output logic       dry_fire,
  output logic       reloading
);

  localparam logic [4:0]       MaxRounds  = 5'(MAX_BULLET);
  localparam logic [CNT_W-1:0] CoolLoad   = CNT_W'(FIRE_COOLDOWN - 1);
  localparam logic [CNT_W-1:0] ReloadLoad = CNT_W'(RELOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCooldown,
    StReload
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             reload_pend_q;
  logic [4:0]       left_q;
  logic             shot_q;
  logic             dry_q;
  logic             reloading_q;

  logic       has_round;
  logic       not_full;
  logic       timer_zero;
  logic       want_reload;
  logic [4:0] left_inc;
  logic [4:0] left_dec;

  assign has_round   = (left_q != 5'd0);
  assign not_full    = (left_q < MaxRounds);
  assign timer_zero  = (timer_q == '0);
  // A reload deferred from cooldown counts as a fresh request on the first idle cycle.
  assign want_reload = reload_req | reload_pend_q;
  assign left_inc    = left_q + 5'd1;
  assign left_dec    = left_q - 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      reload_pend_q <= 1'b0;
      left_q        <= MaxRounds;
      shot_q        <= 1'b0;
      dry_q         <= 1'b0;
      reloading_q   <= 1'b0;
    end else begin
      shot_q <= 1'b0;
      dry_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          reload_pend_q <= 1'b0;
          if (fire_req && has_round) begin
            left_q  <= left_dec;
            shot_q  <= 1'b1;
            timer_q <= CoolLoad;
            state_q <= StCooldown;
          end else begin
            dry_q <= fire_req;
            if (want_reload && not_full) begin
              timer_q     <= ReloadLoad;
              state_q     <= StReload;
              reloading_q <= 1'b1;
            end
          end
        end

        StCooldown: begin
          if (reload_req) begin
            reload_pend_q <= 1'b1;
          end
          if (timer_zero) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StReload: begin
          // Firing aborts the reload, even on the cycle a round would have landed.
          if (fire_req && has_round) begin
            left_q      <= left_dec;
            shot_q      <= 1'b1;
            timer_q     <= CoolLoad;
            state_q     <= StCooldown;
            reloading_q <= 1'b0;
          end else begin
            dry_q <= fire_req;
            if (timer_zero) begin
              left_q <= left_inc;
              if (left_inc == MaxRounds) begin
                state_q     <= StIdle;
                reloading_q <= 1'b0;
              end else begin
                timer_q <= ReloadLoad;
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end

        default: begin
          state_q     <= StIdle;
          reloading_q <= 1'b0;
        end
      endcase
    end
  end

  assign leftBullet = left_q;
  assign shot       = shot_q;
  assign dry_fire   = dry_q;
  assign reloading  = reloading_q;

endmodule

// File: tb/tb_bullet_manager.sv
// Scoreboard bench for bullet_manager: a timestamp-based reference model predicts the
// outputs for every sampled edge and a monitor compares them one cycle later.
module tb_bullet_manager;

  localparam int MaxB = 6;
  localparam int Fc   = 4;
  localparam int Rc   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fire_req = 1'b0;
  logic       reload_req = 1'b0;
  logic [4:0] leftBullet;
  logic       shot;
  logic       dry_fire;
  logic       reloading;

  bullet_manager #(
    .MAX_BULLET   (MaxB),
    .FIRE_COOLDOWN(Fc),
    .RELOAD_CYCLES(Rc),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fire_req  (fire_req),
    .reload_req(reload_req),
    .leftBullet(leftBullet),
    .shot      (shot),
    .dry_fire  (dry_fire),
    .reloading (reloading)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] left;
    logic       shot;
    logic       dry;
    logic       rel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: edge index, last edge still in cooldown, edge of next reload round.
  int m_k, m_left, m_cool_last, m_next_round;
  bit m_rel, m_pend;

  function automatic void model_reset();
    m_left       = MaxB;
    m_rel        = 1'b0;
    m_pend       = 1'b0;
    m_cool_last  = -1;
    m_next_round = 0;
    m_k          = 0;
  endfunction

  function automatic exp_t model_step(bit f, bit r);
    exp_t e;
    bit   s = 1'b0;
    bit   d = 1'b0;
    bit   want;
    if (m_rel) begin
      if (f && m_left > 0) begin
        m_left--;
        s           = 1'b1;
        m_rel       = 1'b0;
        m_cool_last = m_k + Fc;
      end else begin
        d = f;
        if (m_k == m_next_round) begin
          m_left++;
          if (m_left == MaxB) m_rel = 1'b0;
          else m_next_round = m_k + Rc;
        end
      end
    end else if (m_k <= m_cool_last) begin
      if (r) m_pend = 1'b1;
    end else begin
      want   = r || m_pend;
      m_pend = 1'b0;
      if (f && m_left > 0) begin
        m_left--;
        s           = 1'b1;
        m_cool_last = m_k + Fc;
      end else begin
        d = f;
        if (want && m_left < MaxB) begin
          m_rel        = 1'b1;
          m_next_round = m_k + Rc;
        end
      end
    end
    m_k++;
    e.left = 5'(m_left);
    e.shot = s;
    e.dry  = d;
    e.rel  = m_rel;
    return e;
  endfunction

  function automatic void check(string name, exp_t act, exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got left=%0d shot=%b dry=%b rel=%b, want left=%0d shot=%b dry=%b rel=%b",
               name, $time, act.left, act.shot, act.dry, act.rel,
               exp.left, exp.shot, exp.dry, exp.rel);
    end
  endfunction

  task automatic cycle(input bit f, input bit r);
    @(negedge clk);
    fire_req   = f;
    reload_req = r;
    exp_q.push_back(model_step(f, r));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  // Monitor: every edge that had stimulus queued is checked just after the edge.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        act = {leftBullet, shot, dry_fire, reloading};
        check("cycle", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    exp_t rst_val;
    exp_t act;
    rst_val = {5'(MaxB), 3'b000};
    model_reset();
    #1 rst = 1'b1;
    #1;
    act = {leftBullet, shot, dry_fire, reloading};
    check("reset", act, rst_val);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Rapid fire, then a full reload from empty.
    repeat (40) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    idle(52);

    // Empty again, reload to 2 rounds, then abort with a shot.
    repeat (35) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    idle(16);
    cycle(1'b1, 1'b0);
    idle(6);

    // Refill, then a reload requested during cooldown is deferred.
    cycle(1'b0, 1'b1);
    idle(45);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    idle(20);

    // Down to 3 rounds, simultaneous fire+reload, then refill and reload at full.
    repeat (3) begin
      cycle(1'b1, 1'b0);
      idle(5);
    end
    cycle(1'b1, 1'b1);
    idle(12);
    cycle(1'b0, 1'b1);
    idle(40);
    cycle(1'b0, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a reload.
    cycle(1'b1, 1'b0);
    idle(5);
    cycle(1'b0, 1'b1);
    idle(10);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    act = {leftBullet, shot, dry_fire, reloading};
    check("async_reset", act, rst_val);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0);
    idle(6);

    // Random traffic.
    repeat (1500) cycle($urandom_range(3) == 0, $urandom_range(7) == 0);
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bullet_manager.md
# bullet_manager

Ammunition controller for the player weapon. It owns the remaining-round count, accepts fire and reload requests from the input-handling logic, enforces a fire cooldown, and refills the magazine one round at a time during reload. Its `leftBullet` output directly drives the HUD bullet renderer (0..6 bullet icons), and its `shot` pulse triggers projectile spawning in the game logic.

## Interface

Parameters:
- `MAX_BULLET`, default 6: magazine capacity. Legal range 1..31. Must match the renderer's icon count.
- `FIRE_COOLDOWN`, default 2_500_000: cycles locked out after an accepted shot (0.1 s at 25 MHz). Must be ≥1.
- `RELOAD_CYCLES`, default 12_500_000: cycles per round added during reload (0.5 s at 25 MHz). Must be ≥1.
- `CNT_W`, default 24: timer width. Must hold `max(FIRE_COOLDOWN, RELOAD_CYCLES) - 1`.

Ports:
- `clk`, input, 1: system clock, the 25 MHz pixel clock domain.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `fire_req`, input, 1: single-cycle fire request pulse.
- `reload_req`, input, 1: single-cycle reload request pulse.
- `leftBullet`, output, 5: rounds remaining, 0..`MAX_BULLET`. Registered.
- `shot`, output, 1: one-cycle pulse for each accepted fire. Registered.
- `dry_fire`, output, 1: one-cycle pulse when a fire is rejected because the magazine is empty. Registered.
- `reloading`, output, 1: high while the FSM is in RELOAD. Registered.

## Operation

Reset values (asynchronous):
- `leftBullet` = `MAX_BULLET`
- `shot` = 0, `dry_fire` = 0, `reloading` = 0
- state = IDLE, timer = 0, `reload_pend` = 0

Outputs, except `leftBullet`, are pulses or flags recomputed every cycle. The default value of `shot` and `dry_fire` is 0.

FSM states: IDLE, COOLDOWN, RELOAD.

IDLE:
- `fire_req` and `leftBullet` > 0: decrement `leftBullet`, pulse `shot`, load timer = `FIRE_COOLDOWN-1`, go to COOLDOWN.
- `fire_req` and `leftBullet` = 0: pulse `dry_fire`, stay in IDLE. `reload_req` is still honoured on the same cycle.
- `reload_req` (no accepted fire) and `leftBullet` < `MAX_BULLET`: load timer = `RELOAD_CYCLES-1`, go to RELOAD.
- `reload_req` at a full magazine is ignored.
- `fire_req` and `reload_req` on the same cycle with `leftBullet` > 0: fire wins and `reload_req` is dropped.
- If `reload_pend` = 1 on entry to IDLE, it acts as a `reload_req` on the first IDLE cycle and is then cleared.

COOLDOWN:
- `fire_req` is ignored. It produces no pulse, including `dry_fire`.
- `reload_req` sets `reload_pend`.
- Timer = 0: go to IDLE. Otherwise decrement the timer.

RELOAD:
- Timer = 0: increment `leftBullet`.
  - If the new value equals `MAX_BULLET`, go to IDLE.
  - Otherwise reload timer = `RELOAD_CYCLES-1`.
- Timer ≠ 0: decrement the timer.
- `fire_req` with `leftBullet` > 0: abort the reload. Decrement `leftBullet`, pulse `shot`, load the cooldown timer, go to COOLDOWN. A round that would complete on this same cycle is not added; fire takes priority.
- `fire_req` with `leftBullet` = 0: pulse `dry_fire` and continue reloading.
- `reload_req` is ignored.

Arithmetic rules:
- `leftBullet` never underflows below 0 and never exceeds `MAX_BULLET`.
- The timer is unsigned `CNT_W` bits and is only ever loaded or decremented when non-zero.

## Timing

- All requests are sampled at the rising edge of `clk`. Responses are visible in the cycle after that edge (latency 1).
- Shot spacing: `shot` asserted in cycle t means COOLDOWN occupies cycles t..t+`FIRE_COOLDOWN`-1. The earliest next accepted fire is sampled at cycle t+`FIRE_COOLDOWN`, so the minimum shot period is `FIRE_COOLDOWN`+1 cycles.
- Reload pacing: if RELOAD is entered with `reloading` = 1 from cycle r, the k-th round appears on `leftBullet` at cycle r+k·`RELOAD_CYCLES`. `reloading` drops in the same cycle `leftBullet` reaches `MAX_BULLET`.
- Reset mid-operation: outputs return to their reset values immediately, and any cooldown, pending reload or partial reload is discarded.

## Test plan

All scenarios use the overrides `FIRE_COOLDOWN`=4, `RELOAD_CYCLES`=8, `MAX_BULLET`=6.

1. **Rapid fire.** Reset, then assert `fire_req` every cycle for 40 cycles.
   - Expect exactly 6 `shot` pulses spaced 5 cycles apart, with `leftBullet` stepping 5,4,3,2,1,0.
   - Expect a `dry_fire` pulse for each later request sampled in IDLE.
2. **Full reload.** Empty the magazine, then send `reload_req` in IDLE.
   - Expect `reloading` = 1, and `leftBullet` increasing by 1 every 8 cycles up to 6.
   - `reloading` falls in the cycle `leftBullet` = 6; the reload takes 48 cycles total.
3. **Reload abort.** Reload from 0 until `leftBullet` = 2, then pulse `fire_req`.
   - Expect `shot`, `leftBullet` = 1, `reloading` = 0, and the FSM in COOLDOWN.
4. **Pending reload.** Fire once from full, then pulse `reload_req` 2 cycles later during COOLDOWN.
   - RELOAD begins automatically after the cooldown ends.
   - `leftBullet` returns to 6 8 cycles after entry.
5. **Simultaneous requests.** With `leftBullet` = 3, pulse `fire_req` and `reload_req` together: expect `shot`, `leftBullet` = 2, no reload. With a full magazine, pulse `reload_req` alone: expect no state change.
6. **Asynchronous reset.** Assert `rst` mid-RELOAD between clock edges.
   - `leftBullet` = 6 and `reloading` = 0 immediately, without waiting for a clock edge.
   - The first `fire_req` after release is accepted.
